ta_bank: RTL and testbench
==========================

TA_BANK -- requirements
Module: ta_bank

Interface
REQ-001 SHALL have parameter N_TA, default 8: number of Tsetlin automata and literal count, at least 1.
REQ-002 SHALL have parameter STATE_BITS, default 3: automaton state width, at least 2; HALF = 2^(STATE_BITS-1); MAX = 2^STATE_BITS-1.
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  request a cycle; accepted only while ready=1.
REQ-006 SHALL have port clear  in  1  synchronous abort to IDLE.
REQ-007 SHALL have port train  in  1  0 = inference, 1 = inference then update; latched at accept.
REQ-008 SHALL have port fb_type  in  1  0 = Type I feedback, 1 = Type II feedback; latched at accept.
REQ-009 SHALL have port literals  in  N_TA  literal vector; latched at accept.
REQ-010 SHALL have port rand_hi  in  N_TA  per-TA random bit, P ~ (s-1)/s; sampled in UPDATE.
REQ-011 SHALL have port rand_lo  in  N_TA  per-TA random bit, P ~ 1/s; sampled in UPDATE.
REQ-012 SHALL have port ready  out  1  high in IDLE only.
REQ-013 SHALL have port done  out  1  one-cycle pulse in DONE.
REQ-014 SHALL have port clause_out  out  1  registered clause result.
REQ-015 SHALL have port include_mask  out  N_TA  bit i = 1 when state[i] >= HALF.

Function
REQ-016 SHALL implement FSM IDLE -> EVAL -> UPDATE (train=1 only) -> DONE -> IDLE, one cycle per state except IDLE.
REQ-017 SHALL move from IDLE to EVAL on start=1 at a clock edge, latching train, fb_type and literals on that edge.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL, in EVAL, register clause_out = AND of latched literals over included TAs.
REQ-020 SHALL, in EVAL, produce clause_out = 1 for an empty clause (no includes) when train=1 and 0 when train=0.
REQ-021 SHALL assert done in the 2nd cycle after the accepting edge for inference and in the 3rd for training.
REQ-022 SHALL, in UPDATE with Type I and clause_out=1 and literal=1, increment the state when rand_hi[i]=1.
REQ-023 SHALL, in UPDATE with Type I and clause_out=1 and literal=0, decrement the state when rand_lo[i]=1.
REQ-024 SHALL, in UPDATE with Type I and clause_out=0, decrement the state when rand_lo[i]=1.
REQ-025 SHALL, in UPDATE with Type II, increment the state by 1 only when clause_out=1, literal=0 and the TA is excluded; otherwise no change; random inputs ignored.
REQ-026 SHALL saturate every state to the range 0..MAX, so that MAX+1 and -1 never occur.
REQ-027 SHALL update all N_TA automata in the same UPDATE cycle, each independently.
REQ-028 SHALL modify states only in UPDATE.
REQ-029 SHALL, on clear=1 in any non-IDLE state, go to IDLE next cycle with no update and no done, retaining all states; clear takes priority over start.
REQ-030 SHALL hold clause_out until the next EVAL.

Reset
REQ-031 SHALL, on rst, force state IDLE, ready=1, done=0 and clause_out=0.
REQ-032 SHALL, on rst, set every automaton state to HALF-1, giving include_mask=0.
REQ-033 SHALL let rst during EVAL or UPDATE abort the cycle with no partial update surviving.

Configuration
REQ-034 SHALL use macro TA_BANK_BOOST_TPF_EN: when defined, the Type I increment for clause_out=1 and literal=1 is unconditional (rand_hi ignored); when undefined, REQ-022 applies unchanged.

Verification (N_TA=4, STATE_BITS=3, HALF=4, MAX=7)
REQ-035 SHALL cover: rst pulse -> ready=1, done=0, clause_out=0, include_mask=4'b0000, all states 3.
REQ-036 SHALL cover: after reset, start with train=0 and literals=4'b1010 -> done 2 cycles after accept, clause_out=0, states unchanged.
REQ-037 SHALL cover: start with train=1, fb_type=1 and literals=4'b0000 -> clause_out=1, all states 4, include_mask=4'b1111, done 3 cycles after accept.
REQ-038 SHALL cover: from all states 4, five Type I cycles with literals=4'b1111 and rand_hi=4'b1111 -> states reach 7 and hold 7 (saturation), clause_out=1 each time.
REQ-039 SHALL cover: all states 4, Type I, literals=4'b0111 -> clause_out=0; with rand_lo=4'b0000 no change; repeated with rand_lo=4'b0001 TA0 drops to 3 and include_mask becomes 4'b1110.
REQ-040 SHALL cover: start asserted in EVAL is ignored; clear in UPDATE cycle -> IDLE next cycle, no done, states unchanged; with TA_BANK_BOOST_TPF_EN defined, REQ-038 with rand_hi=4'b0000 still increments.

Source files
------------

// File: rtl/ta_bank_if.sv
// ta_bank_if -- handshake, data and status bundle for the ta_bank
// Tsetlin automaton bank.
//
// Parameter:
//   N_TA          number of automata / literal count
// Signals:
//   start         request a cycle (accepted only while ready=1)
//   clear         synchronous abort back to idle
//   train         0 = inference only, 1 = inference then update
//   fb_type       0 = Type I feedback, 1 = Type II feedback
//   literals      literal vector, one bit per automaton
//   rand_hi       per-automaton random bit, P ~ (s-1)/s
//   rand_lo       per-automaton random bit, P ~ 1/s
//   ready         bank is idle and will accept start
//   done          one-cycle completion pulse
//   clause_out    registered clause result
//   include_mask  bit i set when automaton i currently includes its literal
// Modports:
//   master        drives requests and random bits (testbench / controller)
//   slave         the bank itself
interface ta_bank_if #(
    parameter int N_TA = 8
);
    logic            start;
    logic            clear;
    logic            train;
    logic            fb_type;
    logic [N_TA-1:0] literals;
    logic [N_TA-1:0] rand_hi;
    logic [N_TA-1:0] rand_lo;
    logic            ready;
    logic            done;
    logic            clause_out;
    logic [N_TA-1:0] include_mask;

    modport master (
        output start, clear, train, fb_type, literals, rand_hi, rand_lo,
        input  ready, done, clause_out, include_mask
    );

    modport slave (
        input  start, clear, train, fb_type, literals, rand_hi, rand_lo,
        output ready, done, clause_out, include_mask
    );
endinterface

// File: rtl/ta_bank.sv
// ta_bank -- a bank of N_TA Tsetlin automata forming one clause.
// Each accepted request evaluates the clause over the latched literals
// and, when training, applies Type I or Type II feedback to every
// automaton in a single cycle.
//
// Parameters:
//   N_TA        number of automata and literals (>= 1)
//   STATE_BITS  automaton state width (>= 2); states >= HALF include
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   bus         ta_bank_if slave modport (request, random bits, status)
//
// Optional feature:
//   TA_BANK_BOOST_TPF_EN  when defined, the Type I increment for a true
//                         clause on a true literal ignores rand_hi and
//                         always happens (boosted true-positive feedback).
module ta_bank #(
    parameter int N_TA       = 8,
    parameter int STATE_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    ta_bank_if.slave    bus
);

    localparam logic [STATE_BITS-1:0] HALF     = STATE_BITS'(1) << (STATE_BITS - 1);
    localparam logic [STATE_BITS-1:0] MAX      = '1;
    localparam logic [STATE_BITS-1:0] ST_RESET = HALF - 1'b1;

`ifdef TA_BANK_BOOST_TPF_EN
    localparam bit BOOST_TPF = 1'b1;
`else
    localparam bit BOOST_TPF = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        UPDATE,
        DONE
    } fsm_t;

    fsm_t                  fsm;
    logic                  ready_q;
    logic                  done_q;
    logic                  clause_q;
    logic                  train_q;
    logic                  fb_q;
    logic [N_TA-1:0]       lit_q;
    logic [STATE_BITS-1:0] ta_state   [N_TA];
    logic [STATE_BITS-1:0] next_state [N_TA];
    logic [N_TA-1:0]       include_mask;
    logic                  clause_eval;
    logic [N_TA-1:0]       inc_vec;
    logic [N_TA-1:0]       dec_vec;

    // An automaton includes its literal in the upper half of its range.
    always_comb begin
        include_mask = '0;
        for (int i = 0; i < N_TA; i++) begin
            include_mask[i] = (ta_state[i] >= HALF);
        end
    end

    // Excluded literals are masked to 1 so they cannot falsify the AND.
    // An empty clause reads as 1 while training so that it can still
    // attract Type II feedback, and as 0 during plain inference.
    always_comb begin
        if (include_mask == '0) begin
            clause_eval = train_q;
        end else begin
            clause_eval = &(lit_q | ~include_mask);
        end
    end

    // Feedback decision per automaton, then a saturating +/-1 step.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < N_TA; i++) begin
            next_state[i] = ta_state[i];
            if (!fb_q) begin
                if (clause_q && lit_q[i]) begin
                    inc_vec[i] = BOOST_TPF | bus.rand_hi[i];
                end else begin
                    dec_vec[i] = bus.rand_lo[i];
                end
            end else begin
                inc_vec[i] = clause_q && !lit_q[i] && !include_mask[i];
            end
            if (inc_vec[i] && ta_state[i] != MAX) begin
                next_state[i] = ta_state[i] + 1'b1;
            end else if (dec_vec[i] && ta_state[i] != '0) begin
                next_state[i] = ta_state[i] - 1'b1;
            end
        end
    end

    // Control FSM. ready/done/clause_out are registered alongside the
    // state; automaton states only ever change on the UPDATE edge, so a
    // clear or reset before that edge leaves no partial update behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            clause_q <= 1'b0;
            train_q  <= 1'b0;
            fb_q     <= 1'b0;
            lit_q    <= '0;
            for (int i = 0; i < N_TA; i++) begin
                ta_state[i] <= ST_RESET;
            end
        end else begin
            done_q <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (bus.start && !bus.clear) begin
                        fsm     <= EVAL;
                        ready_q <= 1'b0;
                        train_q <= bus.train;
                        fb_q    <= bus.fb_type;
                        lit_q   <= bus.literals;
                    end
                end
                EVAL: begin
                    if (bus.clear) begin
                        fsm     <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clause_q <= clause_eval;
                        if (train_q) begin
                            fsm <= UPDATE;
                        end else begin
                            fsm    <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    if (bus.clear) begin
                        fsm     <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        ta_state <= next_state;
                        fsm      <= DONE;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    fsm     <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    fsm     <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.done         = done_q;
    assign bus.clause_out   = clause_q;
    assign bus.include_mask = include_mask;

endmodule

// File: tb/tb_ta_bank.sv
// tb_ta_bank -- directed self-checking bench for ta_bank (N_TA=4,
// STATE_BITS=3). A transaction-level model of the automata bank tracks
// the expected states, clause result and ready/done schedule; a negedge
// process compares the DUT against it every cycle, and hand-computed
// literal checks pin the model at key points.
module tb_ta_bank;

    localparam int N    = 4;
    localparam int SB   = 3;
    localparam int HALF = 2 ** (SB - 1);
    localparam int MAX  = 2 ** SB - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ta_bank_if #(.N_TA(N)) bus ();

    ta_bank #(.N_TA(N), .STATE_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_compared = 0;
    int n_failed   = 0;

    int model_state [N];
    bit exp_ready   = 1'b1;
    bit exp_done    = 1'b0;
    bit exp_clause  = 1'b0;
    bit check_en    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = (model_state[i] >= HALF);
        return m;
    endfunction

    // Clause = every included literal is 1; empty clause reads as train.
    function automatic bit model_clause(input bit tr, input logic [N-1:0] lits);
        int n_inc = 0;
        bit c = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (model_state[i] >= HALF) begin
                n_inc++;
                if (!lits[i]) c = 1'b0;
            end
        end
        return (n_inc == 0) ? tr : c;
    endfunction

    function automatic void model_update(input bit fb, input bit c, input logic [N-1:0] lits,
                                         input logic [N-1:0] rhi, input logic [N-1:0] rlo);
        bit boost;
        int s [N];
`ifdef TA_BANK_BOOST_TPF_EN
        boost = 1'b1;
`else
        boost = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            s[i] = model_state[i];
            if (!fb) begin
                if (c && lits[i]) begin
                    if (boost || rhi[i]) s[i] = s[i] + 1;
                end else if (rlo[i]) begin
                    s[i] = s[i] - 1;
                end
            end else if (c && !lits[i] && model_state[i] < HALF) begin
                s[i] = s[i] + 1;
            end
            if (s[i] > MAX) s[i] = MAX;
            if (s[i] < 0)   s[i] = 0;
        end
        for (int i = 0; i < N; i++) model_state[i] = s[i];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ready", 32'(bus.ready), 32'(exp_ready));
            checkOutput("done", 32'(bus.done), 32'(exp_done));
            checkOutput("clause_out", 32'(bus.clause_out), 32'(exp_clause));
            checkOutput("include_mask", 32'(bus.include_mask), 32'(model_mask()));
            for (int i = 0; i < N; i++) begin
                checkOutput($sformatf("state%0d", i), 32'(dut.ta_state[i]), 32'(model_state[i]));
            end
        end
    end

    // One request from idle. hold_start keeps start high (with altered
    // literals) through EVAL; clr_upd raises clear during UPDATE.
    task automatic applyStimulus(input bit tr, input bit fb, input logic [N-1:0] lits,
                                 input logic [N-1:0] rhi, input logic [N-1:0] rlo,
                                 input bit hold_start, input bit clr_upd);
        bit c;
        bus.start    = 1'b1;
        bus.train    = tr;
        bus.fb_type  = fb;
        bus.literals = lits;
        bus.rand_hi  = rhi;
        bus.rand_lo  = rlo;
        c = model_clause(tr, lits);
        @(posedge clk); #1;
        exp_ready = 1'b0;
        if (hold_start) bus.literals = ~lits;
        else            bus.start    = 1'b0;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        exp_clause = c;
        if (!tr) begin
            exp_done = 1'b1;
            @(posedge clk); #1;
            exp_done  = 1'b0;
            exp_ready = 1'b1;
        end else if (clr_upd) begin
            bus.clear = 1'b1;
            @(posedge clk); #1;
            bus.clear = 1'b0;
            exp_ready = 1'b1;
        end else begin
            @(posedge clk); #1;
            model_update(fb, c, lits, rhi, rlo);
            exp_done = 1'b1;
            @(posedge clk); #1;
            exp_done  = 1'b0;
            exp_ready = 1'b1;
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.clear    = 1'b0;
        bus.train    = 1'b0;
        bus.fb_type  = 1'b0;
        bus.literals = '0;
        bus.rand_hi  = '0;
        bus.rand_lo  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_clause", 32'(bus.clause_out), 32'd0);
        checkOutput("rst_mask", 32'(bus.include_mask), 32'h0);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("rst_state%0d", i), 32'(dut.ta_state[i]), 32'd3);
            model_state[i] = HALF - 1;
        end
        check_en = 1'b1;

        $display("[TB] inference on empty clause");
        applyStimulus(1'b0, 1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("inf_clause", 32'(bus.clause_out), 32'd0);

        $display("[TB] Type II on empty clause");
        applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("t2_clause", 32'(bus.clause_out), 32'd1);
        checkOutput("t2_mask", 32'(bus.include_mask), 32'hF);
        checkOutput("t2_state0", 32'(dut.ta_state[0]), 32'd4);

        $display("[TB] Type I saturation");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
            checkOutput("sat_clause", 32'(bus.clause_out), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("sat_state%0d", i), 32'(dut.ta_state[i]), 32'd7);
        end

        $display("[TB] Type I false clause back to 4");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0);
        end
        checkOutput("down_state3", 32'(dut.ta_state[3]), 32'd4);

        $display("[TB] Type I false clause with rand_lo");
        applyStimulus(1'b1, 1'b0, 4'b0111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        checkOutput("lo0_clause", 32'(bus.clause_out), 32'd0);
        checkOutput("lo0_mask", 32'(bus.include_mask), 32'hF);
        applyStimulus(1'b1, 1'b0, 4'b0111, 4'b1111, 4'b0001, 1'b0, 1'b0);
        checkOutput("lo1_state0", 32'(dut.ta_state[0]), 32'd3);
        checkOutput("lo1_mask", 32'(bus.include_mask), 32'hE);

        $display("[TB] start held in EVAL, clear in UPDATE");
        applyStimulus(1'b0, 1'b0, 4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("hold_clause", 32'(bus.clause_out), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b1);
        checkOutput("clr_mask", 32'(bus.include_mask), 32'hE);
        checkOutput("clr_state1", 32'(dut.ta_state[1]), 32'd4);

        $display("[TB] Type II on excluded false literal");
        applyStimulus(1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("t2b_state0", 32'(dut.ta_state[0]), 32'd4);
        checkOutput("t2b_state1", 32'(dut.ta_state[1]), 32'd4);

        $display("[TB] Type I true clause with rand_hi low");
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
`ifdef TA_BANK_BOOST_TPF_EN
        checkOutput("boost_state2", 32'(dut.ta_state[2]), 32'd5);
`else
        checkOutput("boost_state2", 32'(dut.ta_state[2]), 32'd4);
`endif

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
